// File: rtl/layer_seq_pkg.sv
// Shared types and constants for the layer sequencer and its testbench.
package layer_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_EN_WAIT,
    S_LOAD,
    S_SCHED,
    S_NEXT,
    S_DIS_WAIT,
    S_POST,
    S_FIN
  } seq_state_t;

  typedef enum logic [1:0] {
    POST_NONE = 2'd0,
    POST_LRN  = 2'd1,
    POST_PAD  = 2'd2,
    POST_RSVD = 2'd3
  } post_op_t;

  localparam int unsigned CONV1_SEG_STRIDE = 385;

endpackage

// File: rtl/layer_sequencer.sv
// Runs one layer: config, per-segment load/schedule, optional LRN/pad post-pass.
// Outputs registered; each phase waits on its done input, so responders set the pace.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int SEG_W   = 4,
  parameter int LAYER_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LAYER_W-1:0] layer_id,
  input  logic               is_conv,
  input  logic [SEG_W-1:0]   num_seg,
  input  logic [ADDR_W-1:0]  seg_stride,
  input  logic [1:0]         post_op,
  output logic               cfg_start,
  output logic               load_start,
  output logic               sched_start,
  output logic               post_start,
  input  logic               cfg_done,
  input  logic               load_done,
  input  logic               sched_done,
  input  logic               post_done,
  output logic               enable_noc,
  output logic               enable_lrn,
  output logic               enable_pad,
  output logic [ADDR_W-1:0]  ipsum_base_addr,
  output logic [ADDR_W-1:0]  opsum_base_addr,
  output logic [SEG_W-1:0]   seg_idx,
  output logic [LAYER_W-1:0] cfg_layer_id,
  output logic               busy,
  output logic               done
);

  seq_state_t        state, state_nxt;
  logic              is_conv_q;
  logic [SEG_W-1:0]  last_seg_q;
  logic [ADDR_W-1:0] stride_q;
  post_op_t          post_q;
  logic [ADDR_W-1:0] base_q;
  logic              accept, seg_adv, last_seg;

  assign accept   = (state == S_IDLE) && start;
  assign last_seg = (seg_idx == last_seg_q);
  assign seg_adv  = (state == S_NEXT) && !last_seg;

  assign ipsum_base_addr = base_q;
  assign opsum_base_addr = base_q;

  // A done is only counted once its own start pulse has dropped.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (start) state_nxt = S_CFG;
      S_CFG:      if (cfg_done && !cfg_start) state_nxt = S_EN_WAIT;
      S_EN_WAIT:  state_nxt = is_conv_q ? S_LOAD : S_SCHED;
      S_LOAD:     if (load_done && !load_start) state_nxt = S_SCHED;
      S_SCHED:    if (sched_done && !sched_start) state_nxt = S_NEXT;
      S_NEXT: begin
        if (last_seg) state_nxt = S_DIS_WAIT;
        else          state_nxt = is_conv_q ? S_LOAD : S_SCHED;
      end
      S_DIS_WAIT: state_nxt = (post_q == POST_LRN || post_q == POST_PAD) ? S_POST : S_FIN;
      S_POST:     if (post_done && !post_start) state_nxt = S_FIN;
      S_FIN:      state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cfg_start    <= 1'b0;
      load_start   <= 1'b0;
      sched_start  <= 1'b0;
      post_start   <= 1'b0;
      enable_noc   <= 1'b0;
      enable_lrn   <= 1'b0;
      enable_pad   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      is_conv_q    <= 1'b0;
      last_seg_q   <= '0;
      stride_q     <= '0;
      post_q       <= POST_NONE;
      cfg_layer_id <= '0;
    end else begin
      state       <= state_nxt;
      cfg_start   <= (state_nxt == S_CFG)   && (state != S_CFG);
      load_start  <= (state_nxt == S_LOAD)  && (state != S_LOAD);
      sched_start <= (state_nxt == S_SCHED) && (state != S_SCHED);
      post_start  <= (state_nxt == S_POST)  && (state != S_POST);
      // EN_WAIT and DIS_WAIT keep every enable low, giving the settle gap.
      enable_noc  <= state_nxt inside {S_LOAD, S_SCHED, S_NEXT};
      enable_lrn  <= (state_nxt == S_POST) && (post_q == POST_LRN);
      enable_pad  <= (state_nxt == S_POST) && (post_q == POST_PAD);
      busy        <= (state_nxt != S_IDLE);
      done        <= (state_nxt == S_FIN);
      if (accept) begin
        is_conv_q    <= is_conv;
        last_seg_q   <= (num_seg == '0) ? '0 : num_seg - SEG_W'(1);
        stride_q     <= seg_stride;
        post_q       <= post_op_t'(post_op);
        cfg_layer_id <= layer_id;
      end
    end
  end

  // Address wraps modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_idx <= '0;
      base_q  <= '0;
    end else if (accept) begin
      seg_idx <= '0;
      base_q  <= '0;
    end else if (seg_adv) begin
      seg_idx <= seg_idx + SEG_W'(1);
      base_q  <= base_q + stride_q;
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with one-cycle-latency responders and a negedge monitor.
module tb_layer_sequencer;
  import layer_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  layer_id = '0;
  logic        is_conv = 1'b0;
  logic [3:0]  num_seg = '0;
  logic [11:0] seg_stride = '0;
  logic [1:0]  post_op = '0;
  logic        cfg_start, load_start, sched_start, post_start;
  logic        cfg_done = 1'b0, load_done = 1'b0, sched_done = 1'b0, post_done = 1'b0;
  logic        enable_noc, enable_lrn, enable_pad;
  logic [11:0] ipsum_base_addr, opsum_base_addr;
  logic [3:0]  seg_idx, cfg_layer_id;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer_id(layer_id), .is_conv(is_conv),
    .num_seg(num_seg), .seg_stride(seg_stride), .post_op(post_op),
    .cfg_start(cfg_start), .load_start(load_start), .sched_start(sched_start),
    .post_start(post_start), .cfg_done(cfg_done), .load_done(load_done),
    .sched_done(sched_done), .post_done(post_done), .enable_noc(enable_noc),
    .enable_lrn(enable_lrn), .enable_pad(enable_pad), .ipsum_base_addr(ipsum_base_addr),
    .opsum_base_addr(opsum_base_addr), .seg_idx(seg_idx), .cfg_layer_id(cfg_layer_id),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Responders: done is high from mid-start-cycle through mid-next-cycle,
  // so the sequencer first counts it one edge after the start pulse.
  logic cfg_hold = 0, load_hold = 0, sched_hold = 0, post_hold = 0;
  logic post_resp_en = 1'b1;
  logic stray_load = 1'b0;
  initial forever begin
    @(negedge clk);
    cfg_done   = cfg_start || cfg_hold;     cfg_hold   = cfg_start;
    load_done  = load_start || load_hold || stray_load; load_hold = load_start;
    sched_done = sched_start || sched_hold; sched_hold = sched_start;
    post_done  = post_resp_en && (post_start || post_hold); post_hold = post_start;
  end

  int ld_cnt, sc_cnt, pst_cnt, dn_cnt, viol;
  logic lrn_seen, pad_seen, prev_noc, prev_ld, prev_sc;
  logic [11:0] ld_addr [0:15];
  logic [11:0] sc_last_addr;
  initial begin
    prev_noc = 0; prev_ld = 0; prev_sc = 0;
    forever begin
      @(negedge clk);
      if (load_start) begin
        if (ld_cnt < 16) ld_addr[ld_cnt] = ipsum_base_addr;
        ld_cnt++;
      end
      if (sched_start) begin
        sc_last_addr = ipsum_base_addr;
        sc_cnt++;
      end
      if (post_start) pst_cnt++;
      if (done) dn_cnt++;
      if (enable_lrn) lrn_seen = 1'b1;
      if (enable_pad) pad_seen = 1'b1;
      if ((enable_noc || prev_noc) && (enable_lrn || enable_pad)) viol++;
      if (enable_lrn && enable_pad) viol++;
      if (ipsum_base_addr !== opsum_base_addr) viol++;
      if ((load_start && prev_ld) || (sched_start && prev_sc)) viol++;
      prev_noc = enable_noc; prev_ld = load_start; prev_sc = sched_start;
    end
  end

  task automatic clear_stats();
    ld_cnt = 0; sc_cnt = 0; pst_cnt = 0; dn_cnt = 0; viol = 0;
    lrn_seen = 0; pad_seen = 0;
  endtask

  // lat = edges after the one sampling start, up to the one raising done; -1 on timeout.
  task automatic run_layer(input logic conv, input logic [3:0] nseg, input logic [11:0] stride,
                           input logic [1:0] pop, output int lat);
    @(negedge clk);
    clear_stats();
    is_conv = conv; num_seg = nseg; seg_stride = stride; post_op = pop;
    layer_id = 4'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cfg_start, load_start, sched_start, post_start, enable_noc, enable_lrn, enable_pad,
         ipsum_base_addr, opsum_base_addr, seg_idx, cfg_layer_id, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b en=%b%b%b addr=%0d seg=%0d, required all 0",
               busy, enable_noc, enable_lrn, enable_pad, ipsum_base_addr, seg_idx);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_pool_latency();
    int lat;
    run_layer(1'b0, 4'd1, 12'd64, 2'd0, lat);
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL pool_latency: got %0d required 7", lat); end
    checks++;
    if (ld_cnt !== 0 || sc_cnt !== 1) begin
      errors++; $display("FAIL pool_starts: load=%0d sched=%0d required 0/1", ld_cnt, sc_cnt);
    end
    checks++;
    if (dn_cnt !== 1 || pst_cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL pool_done: done=%0d post=%0d busy=%b required 1/0/0", dn_cnt, pst_cnt, busy);
    end
    checks++;
    if (cfg_layer_id !== 4'd5) begin
      errors++; $display("FAIL pool_layer_id: got %0d required 5", cfg_layer_id);
    end
  endtask

  task automatic test_conv1();
    int lat;
    run_layer(1'b1, 4'd8, 12'(CONV1_SEG_STRIDE), 2'd1, lat);
    checks++;
    if (lat < 0 || dn_cnt !== 1) begin
      errors++; $display("FAIL conv1_done: lat=%0d done=%0d required finite/1", lat, dn_cnt);
    end
    checks++;
    if (ld_cnt !== 8 || sc_cnt !== 8) begin
      errors++; $display("FAIL conv1_starts: load=%0d sched=%0d required 8/8", ld_cnt, sc_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ld_addr[i] !== 12'(i * 385)) begin
        errors++; $display("FAIL conv1_addr[%0d]: got %0d required %0d", i, ld_addr[i], i * 385);
      end
    end
    checks++;
    if (sc_last_addr !== 12'd2695 || seg_idx !== 4'd7) begin
      errors++; $display("FAIL conv1_last: addr=%0d seg=%0d required 2695/7", sc_last_addr, seg_idx);
    end
    checks++;
    if (pst_cnt !== 1 || lrn_seen !== 1'b1 || pad_seen !== 1'b0 || viol !== 0) begin
      errors++; $display("FAIL conv1_post: post=%0d lrn=%b pad=%b viol=%0d required 1/1/0/0",
                         pst_cnt, lrn_seen, pad_seen, viol);
    end
  endtask

  task automatic test_seg0_reserved();
    int lat;
    run_layer(1'b0, 4'd0, 12'd10, 2'd3, lat);
    checks++;
    if (lat !== 7 || sc_cnt !== 1 || ld_cnt !== 0) begin
      errors++; $display("FAIL seg0: lat=%0d sched=%0d load=%0d required 7/1/0", lat, sc_cnt, ld_cnt);
    end
    checks++;
    if (pst_cnt !== 0 || lrn_seen !== 1'b0 || pad_seen !== 1'b0) begin
      errors++; $display("FAIL post_rsvd: post=%0d lrn=%b pad=%b required 0/0/0", pst_cnt, lrn_seen, pad_seen);
    end
  endtask

  task automatic test_ignored_inputs();
    int lat;
    fork
      run_layer(1'b1, 4'd2, 12'd100, 2'd0, lat);
      begin
        @(negedge clk);
        @(posedge clk);
        #2 stray_load = 1'b1;
        @(posedge clk);
        #2 stray_load = 1'b0;
        repeat (4) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
      end
    join
    checks++;
    if (lat !== 14) begin errors++; $display("FAIL ignored_latency: got %0d required 14", lat); end
    checks++;
    if (ld_cnt !== 2 || sc_cnt !== 2 || dn_cnt !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL ignored_seq: load=%0d sched=%0d done=%0d busy=%b required 2/2/1/0",
                         ld_cnt, sc_cnt, dn_cnt, busy);
    end
    checks++;
    if (ld_addr[1] !== 12'd100) begin
      errors++; $display("FAIL ignored_addr: got %0d required 100", ld_addr[1]);
    end
  endtask

  task automatic test_reset_in_post();
    bit seen;
    seen = 0;
    post_resp_en = 1'b0;
    @(negedge clk);
    clear_stats();
    is_conv = 1'b0; num_seg = 4'd1; seg_stride = 12'd7; post_op = 2'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (enable_pad) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL pad_enable: enable_pad=0 required 1 within 50 cycles"); end
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({cfg_start, load_start, sched_start, post_start, enable_noc, enable_lrn, enable_pad,
         ipsum_base_addr, seg_idx, busy, done} !== '0) begin
      errors++; $display("FAIL reset_mid: busy=%b pad=%b done=%b required all 0", busy, enable_pad, done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    post_resp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dn_cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_done: done=%0d busy=%b required 0/0", dn_cnt, busy);
    end
  endtask

  task automatic test_addr_wrap();
    int lat;
    run_layer(1'b0, 4'd15, 12'd300, 2'd0, lat);
    checks++;
    if (sc_cnt !== 15 || dn_cnt !== 1) begin
      errors++; $display("FAIL wrap_count: sched=%0d done=%0d required 15/1", sc_cnt, dn_cnt);
    end
    checks++;
    if (sc_last_addr !== 12'd104 || ipsum_base_addr !== 12'd104 || seg_idx !== 4'd14) begin
      errors++; $display("FAIL wrap_addr: last=%0d base=%0d seg=%0d required 104/104/14",
                         sc_last_addr, ipsum_base_addr, seg_idx);
    end
  endtask

  initial begin
    test_reset();
    test_pool_latency();
    test_conv1();
    test_seg0_reserved();
    test_ignored_inputs();
    test_reset_in_post();
    test_addr_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Hardware sequencer that runs one network layer end to end: configuration, optional input load per segment, scheduler pass per segment, and an optional LRN or padding post-pass. It sits between the top-level layer controller and the PE-array subsystems: configuration unit, load unit, scheduler, LRN and pad engines. It owns the mutually exclusive `enable_noc`, `enable_lrn` and `enable_pad` selects, and the per-segment psum base addresses.

## Interface
Parameters:
- `ADDR_W`, 12, psum base-address width.
- `SEG_W`, 4, segment-count width (1..15 segments).
- `LAYER_W`, 4, layer-id width.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle pulse; accepted only in IDLE.
- `layer_id`  in  LAYER_W  layer id passed to the configuration unit; sampled on `start`.
- `is_conv`  in  1  1: run load per segment; 0: pool layer, no load. Sampled on `start`.
- `num_seg`  in  SEG_W  number of segments; 0 is treated as 1. Sampled on `start`.
- `seg_stride`  in  ADDR_W  base-address step per segment (conv1 = 385). Sampled on `start`.
- `post_op`  in  2  post-pass: 0 none, 1 LRN, 2 pad, 3 reserved (treated as none). Sampled on `start`.
- `cfg_start`, `load_start`, `sched_start`, `post_start`  out  1  one-cycle start pulses.
- `cfg_done`, `load_done`, `sched_done`, `post_done`  in  1  completion pulses or levels; a single high cycle counts.
- `enable_noc`, `enable_lrn`, `enable_pad`  out  1  subsystem enables; at most one is high.
- `ipsum_base_addr`, `opsum_base_addr`  out  ADDR_W  current segment base; the two are always equal.
- `seg_idx`  out  SEG_W  current segment index.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at layer completion.

## Operation
- States: IDLE → CFG → EN_WAIT → LOAD → SCHED → NEXT → DIS_WAIT → POST → FIN → IDLE.
- IDLE:
  - On `start`, latch all inputs, clear `seg_idx` and the base addresses, pulse `cfg_start`, then go to CFG.
- CFG: wait for `cfg_done`, then go to EN_WAIT.
- EN_WAIT:
  - Hold for one settle cycle.
  - Assert `enable_noc`.
  - If `is_conv`, pulse `load_start` and go to LOAD.
  - Otherwise pulse `sched_start` and go to SCHED.
- LOAD: on `load_done`, pulse `sched_start` and go to SCHED.
- SCHED: wait for `sched_done`, then go to NEXT.
- NEXT:
  - If `seg_idx == num_seg-1`, go to DIS_WAIT.
  - Otherwise: `seg_idx++`; both base addresses += `seg_stride`; pulse `load_start` (conv) or `sched_start` (pool); go to LOAD or SCHED accordingly.
- DIS_WAIT:
  - Hold for one settle cycle.
  - Deassert `enable_noc`.
  - If `post_op` is 1 or 2, assert the matching enable, pulse `post_start` and go to POST.
  - Otherwise go to FIN.
- POST: on `post_done`, drop `enable_lrn`/`enable_pad` and go to FIN.
- FIN: pulse `done`, go to IDLE.
- `start` outside IDLE is ignored.
- A done input that arrives in the wrong state is ignored.
- Address arithmetic is modulo 2^ADDR_W; no saturation.

## Timing
- All outputs are registered.
- Reset values: every output 0; state IDLE.
- Reset asserted mid-layer returns to IDLE next edge and drops all enables; no `done` pulse is issued.
- Every `*_start` pulse is exactly 1 cycle and is never repeated within a phase.
- A done arriving in the same cycle as its start pulse is not counted.
- `enable_noc` rises exactly 1 cycle after leaving CFG.
- `enable_noc` falls exactly 1 cycle after the last `sched_done`.
- `enable_noc` and the post enable are never high in the same cycle; there is at least one zero cycle between them.
- Base-address update and the next `load_start`/`sched_start` are visible in the same cycle.
- Minimum layer latency with zero-latency responders: 1-segment pool, no post-op = 7 cycles from `start` to `done`.

## Structure
- Shared package `layer_seq_pkg`:
  - state enum `seq_state_t`;
  - `post_op_t` enum (`POST_NONE`, `POST_LRN`, `POST_PAD`);
  - constant `CONV1_SEG_STRIDE = 385`.
- Single module, no sub-modules:
  - one FSM `always_ff`;
  - one segment/address counter block;
  - combinational next-state.

## Test plan
- Conv1 profile (`is_conv=1`, `num_seg=8`, `seg_stride=385`, `post_op=LRN`):
  - expect 8 `load_start` and 8 `sched_start`;
  - base addresses step 0, 385, …, 2695;
  - `enable_lrn` only after `enable_noc` falls; single `done`.
- Pool (`is_conv=0`, `num_seg=1`, `post_op=none`):
  - no `load_start`, one `sched_start`;
  - `done` 7 cycles after `start` with immediate responders.
- `num_seg=0` → behaves as 1 segment; `post_op=3` → no `post_start`, `enable_pad`/`enable_lrn` stay 0.
- `start` pulsed during SCHED, and a stray `load_done` during CFG → both ignored; sequence unchanged.
- `rst_n` low during POST with `enable_pad=1` → next cycle all outputs 0, state IDLE, no `done`.
- `num_seg=15`, `seg_stride=300` → final base = 4200 mod 4096 = 104; wrap is silent.
